nds_dmac_arb: RTL and testbench
===============================

# nds_dmac_arb

Channel arbiter and sequencer for the shared DMA transfer engine. It collects transfer requests from up to NUM_CH DMA channels and picks one winner, high priority first and round-robin within a priority level. It hands the winner to the engine through a ready/done handshake and holds the grant until the engine reports completion. It sits between the per-channel control registers and the single engine datapath.

## Interface
- NUM_CH, 8: number of channels, legal range 2..8.
- CH_W, 3: channel index width; must equal ceil(log2(NUM_CH)).
- CK  input  1  clock; all state is on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- ch_req  input  NUM_CH  per-channel transfer request, level-sensitive.
- ch_pri  input  NUM_CH  per-channel priority; 1 means high, 0 means low.
- eng_ready  input  1  engine can accept a new channel this cycle.
- eng_done  input  1  single-cycle pulse marking the end of the granted channel's transfer unit.
- gnt  output  NUM_CH  one-hot grant, registered.
- gnt_id  output  CH_W  binary index of the granted channel, registered.
- gnt_vld  output  1  a grant is presented or active, registered.
- eng_start  output  1  single-cycle pulse; the engine has accepted the grant.

## Operation
- Reset values: state=IDLE, gnt=0, gnt_id=0, gnt_vld=0, eng_start=0, hi_ptr=0, lo_ptr=0.
- The FSM has three states: IDLE, GRANT and BUSY.
- IDLE:
  - If any ch_req bit is set, compute the winner combinationally and register gnt, gnt_id and gnt_vld=1. Next state is GRANT.
  - Otherwise stay in IDLE.
- Winner selection:
  - If any requester has ch_pri=1, search only high-priority requesters. Otherwise search low-priority requesters.
  - The search is circular over index ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1, where ptr is hi_ptr or lo_ptr for the searched level. The first requester found wins.
- GRANT: gnt, gnt_id and gnt_vld are held.
  - eng_ready=1: assert eng_start for one cycle and go to BUSY.
  - ch_req[gnt_id]=0 with eng_ready=0: withdraw. Clear gnt, gnt_id and gnt_vld, go to IDLE, and leave the pointers unchanged.
  - ch_req[gnt_id]=0 with eng_ready=1 in the same cycle: accept takes precedence and the FSM goes to BUSY.
- BUSY: the grant is held. Changes on ch_req and ch_pri are ignored.
  - eng_done=1: clear gnt, gnt_id and gnt_vld, then go to IDLE.
  - On the same edge, update the pointer of the winner's level to (gnt_id+1) mod NUM_CH. The other level's pointer is unchanged.
- eng_done outside BUSY, or eng_ready outside GRANT, is ignored.
- The winner's priority level is latched at grant time, so a change of ch_pri during BUSY does not affect which pointer is updated.
- Pointer wrap: a pointer at NUM_CH-1 goes to 0.

## Timing
- Request to grant: ch_req sampled high in IDLE at edge N gives gnt_vld=1 after edge N+1. Latency is 1 cycle.
- eng_start rises after the edge where GRANT sees eng_ready=1, and lasts exactly one cycle.
- Back-to-back transfers:
  - eng_done at edge M gives gnt_vld=0 in cycle M+1.
  - The next grant appears after edge M+2.
  - The minimum gap between grants is one cycle with gnt_vld=0.
- Simultaneous events:
  - eng_done together with a new ch_req is handled by the IDLE-cycle sequence above.
  - A request arriving during BUSY waits for IDLE.
- RST asserted in any state returns all state and outputs to reset values immediately, with no handshake. The engine must be reset together with this block.

## Configuration
- NDS_DMAC_ARB_PRIO_EN defined: two-level priority as specified above, with separate hi_ptr and lo_ptr.
- NDS_DMAC_ARB_PRIO_EN undefined:
  - ch_pri is ignored, and all channels share a single round-robin pointer, hi_ptr.
  - lo_ptr is not implemented.
  - The port list is unchanged.

## Test plan
- Reset mid-BUSY:
  - Stimulus: grant channel 3, reach BUSY, then pulse RST.
  - Response: gnt=0, gnt_vld=0 and eng_start=0 immediately. State returns to IDLE. After release, a request on channel 3 is granted 1 cycle later.
- Round-robin fairness:
  - Stimulus: ch_req=0xFF, ch_pri=0, eng_ready=1, eng_done 2 cycles after each eng_start.
  - Response: gnt_id sequence 0,1,2,…,7,0 with one idle cycle between grants.
- Priority:
  - Stimulus: ch_req=0x81, ch_pri=0x80.
  - Response: channel 7 is granted first. With NDS_DMAC_ARB_PRIO_EN undefined, channel 0 is granted first.
- Withdraw:
  - Stimulus: grant channel 2 with eng_ready=0, then drop ch_req[2].
  - Response: gnt_vld=0 next cycle and the pointer is still 0. A later request of 0x06 grants channel 1.
- Accept/withdraw race:
  - Stimulus: in GRANT, drop ch_req[gnt_id] in the same cycle as eng_ready=1.
  - Response: eng_start=1 and the FSM enters BUSY.
- Done with pending request:
  - Stimulus: eng_done while ch_req[5] is high and the low pointer is at 5.
  - Response: the pointer goes to 6, and channel 5 is still granted at edge M+2 because it is the only requester.

Source files
------------

// File: rtl/nds_dmac_arb.sv
// nds_dmac_arb: DMA channel arbiter, round-robin within priority level, ready/done engine handshake.
// Define NDS_DMAC_ARB_PRIO_EN for two-level priority with separate hi/lo pointers.
module nds_dmac_arb #(
  parameter int NUM_CH = 8,
  parameter int CH_W = 3
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_pri,
  input  logic              eng_ready,
  input  logic              eng_done,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_id,
  output logic              gnt_vld,
  output logic              eng_start
);
  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;
  state_t state, state_nxt;
  logic [NUM_CH-1:0] gnt_nxt, cand;
  logic [CH_W-1:0] id_nxt, win_id, ptr, hi_ptr, hi_nxt, ptr_inc, idx;
  logic vld_nxt, start_nxt, found;
`ifdef NDS_DMAC_ARB_PRIO_EN
  logic [CH_W-1:0] lo_ptr, lo_nxt;
  logic sel_hi, lvl, lvl_nxt;
  assign sel_hi = |(ch_req & ch_pri);
  assign cand = sel_hi ? ch_req & ch_pri : ch_req & ~ch_pri;
  assign ptr = sel_hi ? hi_ptr : lo_ptr;
`else
  logic unused_pri;
  assign unused_pri = ^ch_pri;
  assign cand = ch_req;
  assign ptr = hi_ptr;
`endif
  assign ptr_inc = (gnt_id == CH_W'(NUM_CH - 1)) ? '0 : gnt_id + 1'b1;
  always_comb begin
    win_id = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win_id = idx;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    gnt_nxt = gnt;
    id_nxt = gnt_id;
    vld_nxt = gnt_vld;
    start_nxt = 1'b0;
    hi_nxt = hi_ptr;
`ifdef NDS_DMAC_ARB_PRIO_EN
    lo_nxt = lo_ptr;
    lvl_nxt = lvl;
`endif
    case (state)
      IDLE: if (|ch_req) begin
        gnt_nxt = NUM_CH'(1) << win_id;
        id_nxt = win_id;
        vld_nxt = 1'b1;
        state_nxt = GRANT;
`ifdef NDS_DMAC_ARB_PRIO_EN
        lvl_nxt = sel_hi;
`endif
      end
      GRANT: if (eng_ready) begin
        start_nxt = 1'b1;
        state_nxt = BUSY;
      end else if (!ch_req[gnt_id]) begin
        gnt_nxt = '0;
        id_nxt = '0;
        vld_nxt = 1'b0;
        state_nxt = IDLE;
      end
      BUSY: if (eng_done) begin
        gnt_nxt = '0;
        id_nxt = '0;
        vld_nxt = 1'b0;
        state_nxt = IDLE;
`ifdef NDS_DMAC_ARB_PRIO_EN
        hi_nxt = lvl ? ptr_inc : hi_ptr;
        lo_nxt = lvl ? lo_ptr : ptr_inc;
`else
        hi_nxt = ptr_inc;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_vld <= 1'b0;
      eng_start <= 1'b0;
      hi_ptr <= '0;
`ifdef NDS_DMAC_ARB_PRIO_EN
      lo_ptr <= '0;
      lvl <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      gnt <= gnt_nxt;
      gnt_id <= id_nxt;
      gnt_vld <= vld_nxt;
      eng_start <= start_nxt;
      hi_ptr <= hi_nxt;
`ifdef NDS_DMAC_ARB_PRIO_EN
      lo_ptr <= lo_nxt;
      lvl <= lvl_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_nds_dmac_arb.sv
// tb_nds_dmac_arb: directed and randomized checks of nds_dmac_arb against a transaction-level model.
module tb_nds_dmac_arb;
  localparam int NUM = 8;
  logic CK, RST, eng_ready, eng_done, gnt_vld, eng_start;
  logic [NUM-1:0] ch_req, ch_pri, gnt;
  logic [2:0] gnt_id;
  int n_cmp, n_bad, m_hi, m_lo, exp_id;
  bit exp_lvl;

  nds_dmac_arb #(.NUM_CH(NUM), .CH_W(3)) dut (
    .CK(CK), .RST(RST), .ch_req(ch_req), .ch_pri(ch_pri), .eng_ready(eng_ready),
    .eng_done(eng_done), .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .eng_start(eng_start)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Winner = requester of the searched level at the smallest circular distance from its pointer.
  function automatic void pick(input logic [NUM-1:0] r, input logic [NUM-1:0] p);
    logic [NUM-1:0] m;
    int ptr, bd, d;
`ifdef NDS_DMAC_ARB_PRIO_EN
    exp_lvl = (r & p) != 0;
    m = exp_lvl ? (r & p) : (r & ~p);
    ptr = exp_lvl ? m_hi : m_lo;
`else
    exp_lvl = 1'b1;
    m = r;
    ptr = m_hi;
`endif
    exp_id = -1;
    bd = NUM;
    for (int c = 0; c < NUM; c++) begin
      d = (c - ptr + NUM) % NUM;
      if (m[c] && d < bd) begin
        bd = d;
        exp_id = c;
      end
    end
  endfunction

  function automatic void retire();
    if (exp_lvl) m_hi = (exp_id + 1) % NUM;
    else m_lo = (exp_id + 1) % NUM;
  endfunction

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    ch_req = '0;
    ch_pri = '0;
    eng_ready = 1'b0;
    eng_done = 1'b0;
    step();
    RST = 1'b0;
    m_hi = 0;
    m_lo = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ch_req = '0;
    ch_pri = '0;
    eng_ready = 1'b0;
    eng_done = 1'b0;
    #1;
    n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL reset_gnt: got %0h want 0", gnt); end
    n_cmp++; if (gnt_id !== 3'd0) begin n_bad++; $display("FAIL reset_id: got %0d want 0", gnt_id); end
    n_cmp++; if (gnt_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", gnt_vld); end
    n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", eng_start); end
    step();
    RST = 1'b0;
    step();
    n_cmp++; if (gnt_vld !== 1'b0) begin n_bad++; $display("FAIL idle_noreq_vld: got %b want 0", gnt_vld); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    ch_req = 8'hFF;
    ch_pri = 8'h00;
    eng_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      pick(ch_req, ch_pri);
      step();
      n_cmp++; if (gnt_vld !== 1'b1 || gnt_id !== 3'(k % NUM)) begin n_bad++; $display("FAIL rr_grant%0d: got vld=%b id=%0d want vld=1 id=%0d", k, gnt_vld, gnt_id, k % NUM); end
      n_cmp++; if (gnt !== 8'(1 << (k % NUM))) begin n_bad++; $display("FAIL rr_onehot%0d: got %0h want %0h", k, gnt, 8'(1 << (k % NUM))); end
      step();
      n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL rr_start%0d: got %b want 1", k, eng_start); end
      step();
      n_cmp++; if (eng_start !== 1'b0 || gnt_vld !== 1'b1) begin n_bad++; $display("FAIL rr_busy%0d: got start=%b vld=%b want start=0 vld=1", k, eng_start, gnt_vld); end
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      retire();
      n_cmp++; if (gnt_vld !== 1'b0) begin n_bad++; $display("FAIL rr_gap%0d: got vld=%b want 0", k, gnt_vld); end
    end
  endtask

  task automatic test_priority();
    int want;
`ifdef NDS_DMAC_ARB_PRIO_EN
    want = 7;
`else
    want = 0;
`endif
    apply_reset();
    ch_req = 8'h81;
    ch_pri = 8'h80;
    step();
    n_cmp++; if (gnt_vld !== 1'b1 || gnt_id !== 3'(want)) begin n_bad++; $display("FAIL prio_first: got vld=%b id=%0d want vld=1 id=%0d", gnt_vld, gnt_id, want); end
  endtask

  task automatic test_withdraw();
    apply_reset();
    ch_req = 8'h04;
    step();
    n_cmp++; if (gnt_id !== 3'd2 || gnt_vld !== 1'b1) begin n_bad++; $display("FAIL wd_grant: got vld=%b id=%0d want vld=1 id=2", gnt_vld, gnt_id); end
    step();
    n_cmp++; if (gnt_vld !== 1'b1 || eng_start !== 1'b0) begin n_bad++; $display("FAIL wd_hold: got vld=%b start=%b want vld=1 start=0", gnt_vld, eng_start); end
    ch_req = 8'h00;
    step();
    n_cmp++; if (gnt_vld !== 1'b0 || gnt !== '0 || gnt_id !== 3'd0) begin n_bad++; $display("FAIL wd_clear: got vld=%b gnt=%0h id=%0d want 0/0/0", gnt_vld, gnt, gnt_id); end
    ch_req = 8'h06;
    step();
    n_cmp++; if (gnt_id !== 3'd1 || gnt_vld !== 1'b1) begin n_bad++; $display("FAIL wd_ptr: got vld=%b id=%0d want vld=1 id=1", gnt_vld, gnt_id); end
  endtask

  task automatic test_race();
    apply_reset();
    ch_req = 8'h08;
    step();
    n_cmp++; if (gnt_id !== 3'd3) begin n_bad++; $display("FAIL race_grant: got %0d want 3", gnt_id); end
    ch_req = 8'h00;
    eng_ready = 1'b1;
    step();
    n_cmp++; if (eng_start !== 1'b1 || gnt_vld !== 1'b1) begin n_bad++; $display("FAIL race_accept: got start=%b vld=%b want 1/1", eng_start, gnt_vld); end
    step();
    n_cmp++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd3) begin n_bad++; $display("FAIL race_busy: got vld=%b id=%0d want 1/3", gnt_vld, gnt_id); end
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    ch_req = 8'hFF;
    step();
    n_cmp++; if (gnt_id !== 3'd4) begin n_bad++; $display("FAIL race_ptr: got %0d want 4", gnt_id); end
  endtask

  task automatic test_done_pending();
    apply_reset();
    eng_ready = 1'b1;
    ch_req = 8'h10;
    step();
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    ch_req = 8'h20;
    step();
    n_cmp++; if (gnt_id !== 3'd5) begin n_bad++; $display("FAIL dp_grant: got %0d want 5", gnt_id); end
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    n_cmp++; if (gnt_vld !== 1'b0) begin n_bad++; $display("FAIL dp_gap: got vld=%b want 0", gnt_vld); end
    step();
    n_cmp++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd5) begin n_bad++; $display("FAIL dp_regrant: got vld=%b id=%0d want 1/5", gnt_vld, gnt_id); end
    step();
    ch_req = 8'hFF;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step();
    n_cmp++; if (gnt_id !== 3'd6) begin n_bad++; $display("FAIL dp_ptr: got %0d want 6", gnt_id); end
  endtask

  task automatic test_reset_busy();
    apply_reset();
    eng_ready = 1'b1;
    ch_req = 8'h08;
    step();
    n_cmp++; if (gnt_id !== 3'd3) begin n_bad++; $display("FAIL rb_grant: got %0d want 3", gnt_id); end
    step();
    n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL rb_start: got %b want 1", eng_start); end
    #2;
    RST = 1'b1;
    #1;
    n_cmp++; if (gnt !== '0 || gnt_vld !== 1'b0 || eng_start !== 1'b0 || gnt_id !== 3'd0) begin n_bad++; $display("FAIL rb_async: got gnt=%0h vld=%b start=%b id=%0d want all 0", gnt, gnt_vld, eng_start, gnt_id); end
    step();
    RST = 1'b0;
    step();
    n_cmp++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd3) begin n_bad++; $display("FAIL rb_regrant: got vld=%b id=%0d want 1/3", gnt_vld, gnt_id); end
  endtask

  task automatic test_random();
    logic [NUM-1:0] r;
    int dly, busy;
    apply_reset();
    for (int t = 0; t < 150; t++) begin
      r = 8'($urandom);
      if (r == '0) r = 8'(1 << $urandom_range(NUM - 1));
      ch_req = r;
      ch_pri = 8'($urandom);
      eng_ready = 1'b0;
      eng_done = 1'($urandom);
      pick(ch_req, ch_pri);
      step();
      n_cmp++; if (gnt_vld !== 1'b1 || gnt_id !== 3'(exp_id) || gnt !== 8'(1 << exp_id)) begin n_bad++; $display("FAIL rnd_grant%0d: got vld=%b id=%0d gnt=%0h want 1/%0d/%0h", t, gnt_vld, gnt_id, gnt, exp_id, 8'(1 << exp_id)); end
      dly = $urandom_range(2);
      for (int d = 0; d < dly; d++) begin
        eng_done = 1'($urandom);
        step();
        n_cmp++; if (gnt_vld !== 1'b1 || eng_start !== 1'b0 || gnt_id !== 3'(exp_id)) begin n_bad++; $display("FAIL rnd_wait%0d: got vld=%b start=%b id=%0d want 1/0/%0d", t, gnt_vld, eng_start, gnt_id, exp_id); end
      end
      eng_ready = 1'b1;
      eng_done = 1'b0;
      step();
      n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL rnd_start%0d: got %b want 1", t, eng_start); end
      busy = $urandom_range(3);
      for (int b = 0; b < busy; b++) begin
        ch_req = 8'($urandom);
        ch_pri = 8'($urandom);
        eng_ready = 1'($urandom);
        step();
        n_cmp++; if (gnt_vld !== 1'b1 || eng_start !== 1'b0 || gnt_id !== 3'(exp_id)) begin n_bad++; $display("FAIL rnd_busy%0d: got vld=%b start=%b id=%0d want 1/0/%0d", t, gnt_vld, eng_start, gnt_id, exp_id); end
      end
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      retire();
      n_cmp++; if (gnt_vld !== 1'b0 || gnt !== '0 || eng_start !== 1'b0) begin n_bad++; $display("FAIL rnd_done%0d: got vld=%b gnt=%0h start=%b want 0/0/0", t, gnt_vld, gnt, eng_start); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_hi = 0;
    m_lo = 0;
    test_reset();
    test_round_robin();
    test_priority();
    test_withdraw();
    test_race();
    test_done_pending();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
